// File: rtl/branch_predictor.sv
// branch_predictor: 2-bit counter direction predictor with execute-stage mispredict redirect and stats
module branch_predictor #(
   parameter int INDEX_BITS = 6,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      pc_f,
   input  logic [31:0]      instr_f,
   output logic             pred_taken_f,
   output logic [31:0]      pred_target_f,
   input  logic             valid_e,
   input  logic [6:0]       instr_opcodeE,
   input  logic [31:0]      pc_e,
   input  logic             br_taken,
   input  logic [31:0]      target_e,
   input  logic             pred_taken_e,
   input  logic             stat_clr,
   output logic             flush,
   output logic [31:0]      redirect_pc,
   output logic [CNT_W-1:0] br_cnt,
   output logic [CNT_W-1:0] mispred_cnt
);
   localparam int NENT = 2 ** INDEX_BITS;
   localparam logic [6:0] OP_B    = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;

   logic [1:0]            ctr_q [NENT];
   logic [1:0]            ctr_d;
   logic [CNT_W-1:0]      br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;
   logic [INDEX_BITS-1:0] idx_f, idx_e;
   logic [31:0]           imm_b, imm_j;
   logic                  is_b_f, is_jal_f, is_b_e, is_jalr_e, mispredict, train;

   assign idx_f    = pc_f[INDEX_BITS+1:2];
   assign idx_e    = pc_e[INDEX_BITS+1:2];
   assign is_b_f   = instr_f[6:0] == OP_B;
   assign is_jal_f = instr_f[6:0] == OP_JAL;
   assign imm_b    = {{19{instr_f[31]}}, instr_f[31], instr_f[7], instr_f[30:25], instr_f[11:8], 1'b0};
   assign imm_j    = {{11{instr_f[31]}}, instr_f[31], instr_f[19:12], instr_f[20], instr_f[30:21], 1'b0};

   // fetch reads the registered table only, so a same-cycle training write is not bypassed
   assign pred_taken_f  = is_b_f ? ctr_q[idx_f][1] : is_jal_f;
   assign pred_target_f = pc_f + (is_b_f ? imm_b : is_jal_f ? imm_j : 32'd4);

   assign is_b_e      = instr_opcodeE == OP_B;
   assign is_jalr_e   = instr_opcodeE == OP_JALR;
   assign mispredict  = is_b_e ? (br_taken ^ pred_taken_e) : is_jalr_e;
   assign flush       = valid_e & mispredict;
   assign redirect_pc = br_taken ? target_e : pc_e + 32'd4;
   assign train       = valid_e & is_b_e;

   always_comb begin
      ctr_d     = br_taken ? ((ctr_q[idx_e] == 2'b11) ? 2'b11 : ctr_q[idx_e] + 2'd1)
                           : ((ctr_q[idx_e] == 2'b00) ? 2'b00 : ctr_q[idx_e] - 2'd1);
      br_cnt_d  = stat_clr ? '0 : (valid_e & (is_b_e | is_jalr_e) & ~&br_cnt_q) ? br_cnt_q + CNT_W'(1) : br_cnt_q;
      mis_cnt_d = stat_clr ? '0 : (flush & ~&mis_cnt_q) ? mis_cnt_q + CNT_W'(1) : mis_cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NENT; i++) ctr_q[i] <= 2'b01;
         br_cnt_q  <= '0;
         mis_cnt_q <= '0;
      end else begin
         if (train) ctr_q[idx_e] <= ctr_d;
         br_cnt_q  <= br_cnt_d;
         mis_cnt_q <= mis_cnt_d;
      end
   end

   assign br_cnt      = br_cnt_q;
   assign mispred_cnt = mis_cnt_q;
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed and random stimulus, queue scoreboard against an arithmetic reference model
module tb_branch_predictor;
   localparam int IB  = 6;
   localparam int CW  = 4;
   localparam int SAT = 2 ** CW - 1;
   localparam logic [6:0] OP_B    = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;

   logic          clk = 1'b0, rst_n = 1'b0;
   logic [31:0]   pc_f = '0, instr_f = '0, pc_e = '0, target_e = '0;
   logic          valid_e = 1'b0, br_taken = 1'b0, pred_taken_e = 1'b0, stat_clr = 1'b0;
   logic [6:0]    instr_opcodeE = '0;
   logic          pred_taken_f, flush;
   logic [31:0]   pred_target_f, redirect_pc;
   logic [CW-1:0] br_cnt, mispred_cnt;

   always #5 clk = ~clk;

   branch_predictor #(.INDEX_BITS(IB), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .pc_f(pc_f), .instr_f(instr_f),
      .pred_taken_f(pred_taken_f), .pred_target_f(pred_target_f),
      .valid_e(valid_e), .instr_opcodeE(instr_opcodeE), .pc_e(pc_e),
      .br_taken(br_taken), .target_e(target_e), .pred_taken_e(pred_taken_e),
      .stat_clr(stat_clr), .flush(flush), .redirect_pc(redirect_pc),
      .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
   );

   typedef struct {
      int            tag;
      logic          pt;
      logic [31:0]   tgt;
      logic          fl;
      logic [31:0]   rp;
      logic [CW-1:0] bc;
      logic [CW-1:0] mc;
   } exp_t;

   exp_t sbq[$];
   int   n_cmp = 0, n_bad = 0, tag = 0;
   int   m_ctr[2**IB];
   int   m_bc, m_mc;

   task automatic cmp(input string nm, input int tg, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s (step %0d): got %h, expected %h", nm, tg, act, exp);
      end
   endtask

   function automatic int imm_b(input logic [31:0] i);
      return (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
   endfunction

   function automatic int imm_j(input logic [31:0] i);
      return (i[31] ? -1048576 : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
   endfunction

   function automatic logic [31:0] enc_b(input int imm);
      logic [31:0] v;
      v = imm;
      return {v[12], v[10:5], 5'd0, 5'd0, 3'd0, v[4:1], v[11], OP_B};
   endfunction

   function automatic logic [31:0] enc_j(input int imm);
      logic [31:0] v;
      v = imm;
      return {v[20], v[10:1], v[11], v[19:12], 5'd0, OP_JAL};
   endfunction

   task automatic model_reset();
      foreach (m_ctr[k]) m_ctr[k] = 1;
      m_bc = 0;
      m_mc = 0;
   endtask

   // one cycle: drive after the edge, queue what the outputs must show this cycle, then advance the model
   task automatic step(input logic rst, input logic [31:0] pcf, input logic [31:0] ins, input logic ve,
                       input logic [6:0] ope, input logic [31:0] pce, input logic bt,
                       input logic [31:0] tge, input logic pte, input logic clr);
      exp_t        e;
      logic [31:0] off;
      int          fi, ei;
      logic        mis;
      @(posedge clk);
      #1;
      rst_n = rst; pc_f = pcf; instr_f = ins; valid_e = ve; instr_opcodeE = ope;
      pc_e = pce; br_taken = bt; target_e = tge; pred_taken_e = pte; stat_clr = clr;
      if (!rst) model_reset();
      fi    = int'(pcf[IB+1:2]);
      ei    = int'(pce[IB+1:2]);
      off   = (ins[6:0] == OP_B) ? imm_b(ins) : (ins[6:0] == OP_JAL) ? imm_j(ins) : 4;
      mis   = ve && ((ope == OP_B) ? (bt != pte) : (ope == OP_JALR));
      e.tag = tag++;
      e.pt  = (ins[6:0] == OP_B) ? (m_ctr[fi] >= 2) : (ins[6:0] == OP_JAL);
      e.tgt = pcf + off;
      e.fl  = mis;
      e.rp  = bt ? tge : pce + 32'd4;
      e.bc  = CW'(m_bc);
      e.mc  = CW'(m_mc);
      sbq.push_back(e);
      if (rst) begin
         if (ve && ope == OP_B) m_ctr[ei] = bt ? ((m_ctr[ei] < 3) ? m_ctr[ei] + 1 : 3)
                                                : ((m_ctr[ei] > 0) ? m_ctr[ei] - 1 : 0);
         if (clr) begin
            m_bc = 0;
            m_mc = 0;
         end else begin
            if (ve && (ope == OP_B || ope == OP_JALR) && m_bc < SAT) m_bc++;
            if (mis && m_mc < SAT) m_mc++;
         end
      end
   endtask

   task automatic idle_fetch(input logic [31:0] pcf, input logic [31:0] ins);
      step(1'b1, pcf, ins, 1'b0, 7'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sbq.size() != 0) begin
         e = sbq.pop_front();
         cmp("pred_taken_f", e.tag, 32'(pred_taken_f), 32'(e.pt));
         cmp("pred_target_f", e.tag, pred_target_f, e.tgt);
         cmp("flush", e.tag, 32'(flush), 32'(e.fl));
         cmp("redirect_pc", e.tag, redirect_pc, e.rp);
         cmp("br_cnt", e.tag, 32'(br_cnt), 32'(e.bc));
         cmp("mispred_cnt", e.tag, 32'(mispred_cnt), 32'(e.mc));
      end
   end

   initial begin
      logic [31:0] pf, pe, ins;
      logic [6:0]  op;
      int          r;
      model_reset();
      step(1'b0, 32'h100, enc_b(16), 1'b0, 7'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      cmp("reset_pred_b", -1, 32'(pred_taken_f), 32'd0);
      for (int i = 0; i < 2**IB; i++) idle_fetch(32'(i * 4), enc_b(-32));
      step(1'b1, 32'h0, 32'h0, 1'b1, OP_B, 32'h100, 1'b1, 32'h110, 1'b0, 1'b0);
      @(negedge clk);
      cmp("beq_flush", -1, 32'(flush), 32'd1);
      cmp("beq_redirect", -1, redirect_pc, 32'h110);
      idle_fetch(32'h100, enc_b(16));
      @(negedge clk);
      cmp("beq_trained_pred", -1, 32'(pred_taken_f), 32'd1);
      cmp("beq_mispred_cnt", -1, 32'(mispred_cnt), 32'd1);
      cmp("beq_br_cnt", -1, 32'(br_cnt), 32'd1);
      repeat (4) step(1'b1, 32'h0, 32'h0, 1'b1, OP_B, 32'h200, 1'b1, 32'h240, 1'b1, 1'b0);
      step(1'b1, 32'h0, 32'h0, 1'b1, OP_B, 32'h200, 1'b0, 32'h240, 1'b1, 1'b0);
      idle_fetch(32'h200, enc_b(64));
      @(negedge clk);
      cmp("weak_t_still_taken", -1, 32'(pred_taken_f), 32'd1);
      repeat (5) step(1'b1, 32'h0, 32'h0, 1'b1, OP_B, 32'h200, 1'b1, 32'h240, 1'b1, 1'b0);
      idle_fetch(32'h300, enc_j(-8));
      @(negedge clk);
      cmp("jal_pred", -1, 32'(pred_taken_f), 32'd1);
      cmp("jal_target", -1, pred_target_f, 32'h2F8);
      step(1'b1, 32'h0, 32'h0, 1'b1, OP_JAL, 32'h300, 1'b1, 32'h2F8, 1'b1, 1'b0);
      @(negedge clk);
      cmp("jal_exec_flush", -1, 32'(flush), 32'd0);
      step(1'b1, 32'h0, 32'h0, 1'b1, OP_JALR, 32'h400, 1'b1, 32'h4000, 1'b0, 1'b0);
      @(negedge clk);
      cmp("jalr_flush", -1, 32'(flush), 32'd1);
      cmp("jalr_redirect", -1, redirect_pc, 32'h4000);
      step(1'b1, 32'h0, 32'h0, 1'b0, OP_JALR, 32'h400, 1'b1, 32'h4000, 1'b0, 1'b0);
      @(negedge clk);
      cmp("jalr_invalid_flush", -1, 32'(flush), 32'd0);
      step(1'b1, 32'h14, enc_b(8), 1'b1, OP_B, 32'h14, 1'b1, 32'h1C, 1'b0, 1'b0);
      @(negedge clk);
      cmp("collision_old", -1, 32'(pred_taken_f), 32'd0);
      idle_fetch(32'h14, enc_b(8));
      @(negedge clk);
      cmp("collision_new", -1, 32'(pred_taken_f), 32'd1);
      repeat (20) step(1'b1, 32'h0, 32'h0, 1'b1, OP_JALR, 32'h500, 1'b1, 32'h800, 1'b0, 1'b0);
      idle_fetch(32'h0, 32'h0);
      @(negedge clk);
      cmp("br_cnt_sat", -1, 32'(br_cnt), SAT);
      cmp("mispred_cnt_sat", -1, 32'(mispred_cnt), SAT);
      step(1'b1, 32'h0, 32'h0, 1'b1, OP_JALR, 32'h500, 1'b1, 32'h800, 1'b0, 1'b1);
      idle_fetch(32'h0, 32'h0);
      @(negedge clk);
      cmp("clr_br_cnt", -1, 32'(br_cnt), 32'd0);
      cmp("clr_mispred_cnt", -1, 32'(mispred_cnt), 32'd0);
      repeat (2) step(1'b1, 32'h0, 32'h0, 1'b1, OP_B, 32'h24, 1'b1, 32'h40, 1'b1, 1'b0);
      idle_fetch(32'h24, enc_b(8));
      @(negedge clk);
      cmp("pre_reset_taken", -1, 32'(pred_taken_f), 32'd1);
      step(1'b0, 32'h24, enc_b(8), 1'b0, 7'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      cmp("mid_reset_pred", -1, 32'(pred_taken_f), 32'd0);
      cmp("mid_reset_flush", -1, 32'(flush), 32'd0);
      for (int n = 0; n < 3000; n++) begin
         r   = int'($urandom_range(0, 9));
         op  = (r < 5) ? OP_B : (r < 7) ? OP_JAL : (r == 7) ? OP_JALR : 7'($urandom);
         ins = $urandom;
         ins[6:0] = op;
         pf  = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 7) * 4);
         pe  = ($urandom_range(0, 3) == 0) ? pf : ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 7) * 4);
         r   = int'($urandom_range(0, 9));
         step($urandom_range(0, 299) != 0, pf, ins, $urandom_range(0, 3) != 0,
              (r < 5) ? OP_B : (r < 7) ? OP_JAL : (r == 7) ? OP_JALR : 7'($urandom),
              pe, 1'($urandom), $urandom, 1'($urandom), $urandom_range(0, 49) == 0);
      end
      repeat (4) @(negedge clk);
      if (sbq.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", sbq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
